// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline control: load/flush strobes from a RUN/MEM_WAIT/DRAIN FSM.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush/bubble counters.
module pipeline_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       if_rdy,
   input  logic       mem_rdy,
   input  logic       de_valid,
   input  logic       exe_valid,
   input  logic [6:0] opcode_exec,
   input  logic       br_en,
   input  logic [4:0] dec_rs1,
   input  logic [4:0] dec_rs2,
   input  logic [4:0] exe_rd,
   input  logic       exe_is_load,
   output logic       load_pc,
   output logic [1:0] pcmux_sel,
   output logic       fet_dec_load,
   output logic       dec_exe_load,
   output logic       exe_mem_load,
   output logic       mem_wb_load,
   output logic       fet_dec_rst,
   output logic       dec_exe_rst,
   output logic       exe_mem_rst,
   output logic       mem_wb_rst,
   output logic [1:0] seq_state
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic [31:0] bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2
   } state_t;

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_BR   = 7'b1100011;

   localparam logic [1:0] PC_ALU  = 2'd1;
   localparam logic [1:0] PC_JALR = 2'd2;

   state_t state_q;
   state_t state_d;
   logic   redirect;
   logic   load_use;

   always_comb begin
      redirect = exe_valid && ((opcode_exec == OP_JAL) || (opcode_exec == OP_JALR) ||
                               ((opcode_exec == OP_BR) && br_en));
      load_use = de_valid && exe_valid && exe_is_load && (exe_rd != 5'd0) &&
                 (((dec_rs1 != 5'd0) && (dec_rs1 == exe_rd)) ||
                  ((dec_rs2 != 5'd0) && (dec_rs2 == exe_rd)));
   end

   always_comb begin
      state_d      = RUN;
      load_pc      = 1'b0;
      pcmux_sel    = 2'd0;
      fet_dec_load = 1'b0;
      dec_exe_load = 1'b0;
      exe_mem_load = 1'b0;
      mem_wb_load  = 1'b0;
      fet_dec_rst  = 1'b0;
      dec_exe_rst  = 1'b0;
      exe_mem_rst  = 1'b0;
      mem_wb_rst   = 1'b0;
      if (rst) begin
         fet_dec_rst = 1'b1;
         dec_exe_rst = 1'b1;
         exe_mem_rst = 1'b1;
         mem_wb_rst  = 1'b1;
      end else if (!mem_rdy) begin
         mem_wb_rst = 1'b1;
         state_d    = MEM_WAIT;
      end else if (redirect) begin
         load_pc      = 1'b1;
         pcmux_sel    = (opcode_exec == OP_JALR) ? PC_JALR : PC_ALU;
         fet_dec_rst  = 1'b1;
         dec_exe_rst  = 1'b1;
         exe_mem_load = 1'b1;
         mem_wb_load  = 1'b1;
         state_d      = if_rdy ? RUN : DRAIN;
      end else begin
         // A fetch issued before a redirect is still in flight until if_rdy; its data is dropped.
         state_d      = ((state_q == DRAIN) && !if_rdy) ? DRAIN : RUN;
         exe_mem_load = 1'b1;
         mem_wb_load  = 1'b1;
         if (load_use) begin
            dec_exe_rst = 1'b1;
         end else if ((state_q == DRAIN) || !if_rdy) begin
            fet_dec_rst  = 1'b1;
            dec_exe_load = 1'b1;
         end else begin
            load_pc      = 1'b1;
            fet_dec_load = 1'b1;
            dec_exe_load = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign seq_state = state_q;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic        stall_ev, flush_ev, bubble_ev;

   always_comb begin
      stall_ev     = !mem_rdy;
      flush_ev     = mem_rdy && redirect;
      bubble_ev    = mem_rdy && !redirect && load_use;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall_ev && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (flush_ev && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
      if (bubble_ev && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q  <= 32'd0;
         flush_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
